// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and op encoding for the multiply/divide scheduler
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    RESP = 2'd3
  } state_e;

  localparam logic OP_MUL = 1'b1;
  localparam logic OP_DIV = 1'b0;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter; grant is one-hot or zero
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // prio_q names the requester that wins a tie
  logic prio_q, prio_d;

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = prio_q ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  always_comb begin
    prio_d = prio_q;
    if (advance && (gnt != 2'b00)) begin
      prio_d = gnt[0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/muldiv_sched.sv
// rtl/muldiv_sched.sv - schedules two requesters onto a shared multiplier/divider
// Optional CALC watchdog: define MULDIV_TIMEOUT_EN.
module muldiv_sched
  import muldiv_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 mul0,
  input  logic                 mul1,
  input  logic [WIDTH-1:0]     a0,
  input  logic [WIDTH-1:0]     b0,
  input  logic [WIDTH-1:0]     a1,
  input  logic [WIDTH-1:0]     b1,
  output logic [1:0]           ack,
  output logic                 rsp_valid,
  output logic                 rsp_id,
  output logic [2*WIDTH-1:0]   rsp_res,
  output logic                 rsp_err,
  output logic                 em,
  output logic                 ed,
  output logic                 read,
  output logic [WIDTH-1:0]     op_a,
  output logic [WIDTH-1:0]     op_b,
  input  logic [2*WIDTH-1:0]   mult_s,
  input  logic [WIDTH-1:0]     div_q,
  input  logic [WIDTH-1:0]     div_r,
  input  logic                 done_m,
  input  logic                 done_d
);

  state_e state_q, state_d;

  logic               op_q, op_d;
  logic               id_q, id_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] rsp_res_q, rsp_res_d;
  logic               rsp_id_q, rsp_id_d;
  logic               rsp_err_q, rsp_err_d;

  logic [1:0]         gnt;
  logic               grant_valid;
  logic               sel1;
  logic               sel_mul;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;
  logic               div_by_zero;
  logic               unit_done;
  logic               calc_expired;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({req1, req0}),
    .advance (grant_valid),
    .gnt     (gnt)
  );

  assign grant_valid = rst_n && (state_q == IDLE) && (gnt != 2'b00);
  assign sel1        = gnt[1];
  assign sel_mul     = sel1 ? mul1 : mul0;
  assign sel_a       = sel1 ? a1 : a0;
  assign sel_b       = sel1 ? b1 : b0;
  assign div_by_zero = (sel_mul == OP_DIV) && (sel_b == '0);

  // Only the completion of the unit actually running counts
  assign unit_done = (op_q == OP_MUL) ? done_m : done_d;

`ifdef MULDIV_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [CNT_W-1:0] calc_cnt_q, calc_cnt_d;

  always_comb begin
    calc_cnt_d = '0;
    if (state_q == CALC) begin
      calc_cnt_d = calc_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      calc_cnt_q <= '0;
    end else begin
      calc_cnt_q <= calc_cnt_d;
    end
  end

  // Fires on the TIMEOUT-th CALC cycle without a matching done
  assign calc_expired = (state_q == CALC) && (calc_cnt_q == CNT_W'(TIMEOUT - 1));
`else
  assign calc_expired = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    id_d      = id_q;
    a_d       = a_q;
    b_d       = b_q;
    rsp_res_d = rsp_res_q;
    rsp_id_d  = rsp_id_q;
    rsp_err_d = rsp_err_q;
    unique case (state_q)
      IDLE: begin
        if (grant_valid) begin
          op_d = sel_mul;
          id_d = sel1;
          a_d  = sel_a;
          b_d  = sel_b;
          if (div_by_zero) begin
            rsp_res_d = {sel_a, {WIDTH{1'b1}}};
            rsp_id_d  = sel1;
            rsp_err_d = 1'b1;
            state_d   = RESP;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        state_d = CALC;
      end
      CALC: begin
        if (unit_done) begin
          rsp_res_d = (op_q == OP_MUL) ? mult_s : {div_r, div_q};
          rsp_id_d  = id_q;
          rsp_err_d = 1'b0;
          state_d   = RESP;
        end else if (calc_expired) begin
          rsp_res_d = '0;
          rsp_id_d  = id_q;
          rsp_err_d = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= OP_DIV;
      id_q      <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      rsp_res_q <= '0;
      rsp_id_q  <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      id_q      <= id_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rsp_res_q <= rsp_res_d;
      rsp_id_q  <= rsp_id_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  // Enables are qualified by rst_n so an abort drops them without waiting for the edge
  assign ack       = grant_valid ? gnt : 2'b00;
  assign em        = rst_n && (state_q == CALC) && (op_q == OP_MUL);
  assign ed        = rst_n && (state_q == CALC) && (op_q == OP_DIV);
  assign read      = (state_q != CALC);
  assign rsp_valid = rst_n && (state_q == RESP);
  assign rsp_id    = rsp_id_q;
  assign rsp_res   = rsp_res_q;
  assign rsp_err   = rsp_err_q;
  assign op_a      = a_q;
  assign op_b      = b_q;

endmodule

// File: tb/tb_muldiv_sched.sv
// tb/tb_muldiv_sched.sv - directed self-checking bench for muldiv_sched
module tb_muldiv_sched;

  localparam int WIDTH   = 16;
  localparam int TIMEOUT = 64;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req0 = 1'b0, req1 = 1'b0;
  logic              mul0 = 1'b0, mul1 = 1'b0;
  logic [WIDTH-1:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [1:0]        ack;
  logic              rsp_valid, rsp_id, rsp_err;
  logic [2*WIDTH-1:0] rsp_res;
  logic              em, ed, read;
  logic [WIDTH-1:0]  op_a, op_b;
  logic [2*WIDTH-1:0] mult_s;
  logic [WIDTH-1:0]  div_q, div_r;
  logic              done_m, done_d;

  logic              hold_done = 1'b0;
  logic              force_dd  = 1'b0;
  logic [7:0]        cyc_q = 8'd0;
  int                overlap_cnt = 0;
  int                ed_cnt = 0;
  int                n_pass = 0;
  int                n_total = 0;

  always #5 clk = ~clk;

  muldiv_sched #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .mul0(mul0), .mul1(mul1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .ack(ack), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_res(rsp_res), .rsp_err(rsp_err),
    .em(em), .ed(ed), .read(read), .op_a(op_a), .op_b(op_b),
    .mult_s(mult_s), .div_q(div_q), .div_r(div_r), .done_m(done_m), .done_d(done_d)
  );

  // Behavioural unit: completes on the third enabled cycle unless held off
  always @(posedge clk) cyc_q <= (em || ed) ? cyc_q + 8'd1 : 8'd0;
  assign mult_s = {16'd0, op_a} * {16'd0, op_b};
  assign div_q  = (op_b != 0) ? op_a / op_b : '1;
  assign div_r  = (op_b != 0) ? op_a % op_b : op_a;
  assign done_m = em && (cyc_q == 8'd2) && !hold_done;
  assign done_d = (ed && (cyc_q == 8'd2) && !hold_done) || force_dd;

  always @(negedge clk) begin
    if (em && ed) overlap_cnt <= overlap_cnt + 1;
    if (ed) ed_cnt <= ed_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic id, input logic mul,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] exp_res, input logic exp_err, input int exp_lat);
    int w;
    int lat;
    if (id) begin mul1 = mul; a1 = a; b1 = b; req1 = 1'b1; end
    else    begin mul0 = mul; a0 = a; b0 = b; req0 = 1'b1; end
    #1;
    w = 0;
    while (ack == 2'b00 && w < 20) begin tick(); w++; end
    check({tag, "_ack"}, ack, id ? 2'b10 : 2'b01);
    tick();
    if (id) req1 = 1'b0; else req0 = 1'b0;
    lat = 1;
    if (exp_lat > 1) begin
      check({tag, "_load_read"}, read, 1'b1);
      check({tag, "_load_en"}, {em, ed}, 2'b00);
      check({tag, "_load_opa"}, op_a, a);
      check({tag, "_load_opb"}, op_b, b);
    end
    while (!rsp_valid && lat < 200) begin
      tick();
      lat++;
      if (lat == 2 && exp_lat > 2) begin
        check({tag, "_calc_read"}, read, 1'b0);
        check({tag, "_calc_en"}, {em, ed}, {mul, ~mul});
      end
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_id"}, rsp_id, id);
    check({tag, "_res"}, rsp_res, exp_res);
    check({tag, "_err"}, rsp_err, exp_err);
    tick();
    check({tag, "_valid_pulse"}, rsp_valid, 1'b0);
    check({tag, "_res_hold"}, rsp_res, exp_res);
  endtask

  initial begin
    logic [1:0]  exp_ack [3];
    logic [31:0] exp_b2b [3];
    int w;
    int ed_before;
    int seen;

    exp_ack = '{2'b01, 2'b10, 2'b01};
    exp_b2b = '{32'd6, 32'd20, 32'd6};

    tick();
    req0 = 1'b1;
    tick();
    check("rst_ack", ack, 2'b00);
    check("rst_valid", rsp_valid, 1'b0);
    check("rst_id", rsp_id, 1'b0);
    check("rst_res", rsp_res, 32'h0);
    check("rst_err", rsp_err, 1'b0);
    check("rst_em_ed", {em, ed}, 2'b00);
    check("rst_read", read, 1'b1);
    check("rst_opa", op_a, 16'h0);
    check("rst_opb", op_b, 16'h0);
    req0 = 1'b0;
    rst_n = 1'b1;
    tick();

    // Multiply; a stray divider done must not end the operation
    force_dd = 1'b1;
    run_op("mul0", 1'b0, 1'b1, 16'h1234, 16'h0010, 32'h0001_2340, 1'b0, 5);
    force_dd = 1'b0;

    run_op("div1", 1'b1, 1'b0, 16'd100, 16'd7, {16'd2, 16'd14}, 1'b0, 5);

    // Both held: pointer favours 0 here, so order is 0,1,0
    mul0 = 1'b1; a0 = 16'd2; b0 = 16'd3;
    mul1 = 1'b1; a1 = 16'd4; b1 = 16'd5;
    req0 = 1'b1; req1 = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      w = 0;
      while (ack == 2'b00 && w < 20) begin tick(); w++; end
      check($sformatf("b2b_ack%0d", k), ack, exp_ack[k]);
      tick();
      if (k == 2) begin req0 = 1'b0; req1 = 1'b0; end
      check($sformatf("b2b_noack%0d", k), ack, 2'b00);
      w = 0;
      while (!rsp_valid && w < 50) begin tick(); w++; end
      check($sformatf("b2b_id%0d", k), rsp_id, exp_ack[k][1]);
      check($sformatf("b2b_res%0d", k), rsp_res, exp_b2b[k]);
      tick();
    end
    check("b2b_overlap", overlap_cnt, 0);

    // Divide by zero from requester 0 alone while the pointer favours 1
    ed_before = ed_cnt;
    run_op("div0", 1'b0, 1'b0, 16'h00FF, 16'h0000, {16'h00FF, 16'hFFFF}, 1'b1, 1);
    check("div0_no_ed", ed_cnt - ed_before, 0);

    // Reset during CALC aborts silently
    hold_done = 1'b1;
    mul1 = 1'b1; a1 = 16'd3; b1 = 16'd5; req1 = 1'b1;
    #1;
    w = 0;
    while (ack == 2'b00 && w < 20) begin tick(); w++; end
    check("abort_ack", ack, 2'b10);
    tick();
    req1 = 1'b0;
    tick();
    tick();
    check("abort_em_before", em, 1'b1);
    rst_n = 1'b0;
    #1;
    check("abort_em_same", {em, ed}, 2'b00);
    tick();
    check("abort_em_next", {em, ed}, 2'b00);
    check("abort_valid", rsp_valid, 1'b0);
    rst_n = 1'b1;
    hold_done = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid) seen++;
      tick();
    end
    check("abort_no_rsp", seen, 0);
    run_op("post_rst", 1'b1, 1'b1, 16'd3, 16'd5, 32'd15, 1'b0, 5);

`ifdef MULDIV_TIMEOUT_EN
    hold_done = 1'b1;
    run_op("tmo", 1'b0, 1'b1, 16'h0101, 16'h0202, 32'h0, 1'b1, TIMEOUT + 2);
    hold_done = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
